reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset generator for the keyboard controller. It replaces the single power-on/Fn-hold reset with an N-domain sequencer:
- a power-on hold;
- a staged, ordered release of per-domain resets;
- a long-press Fn-key reset that re-runs the whole sequence.

It sits at the top level between the board clock/reset and every clocked block.

## Interface
- `PRESCALE_W`, 16: prescaler width; one tick every 2^PRESCALE_W clocks.
- `CNT_W`, 32: width of the tick counter.
- `POR_TICKS`, 2: ticks spent in power-on hold (≥1).
- `STAGE_TICKS`, 1: ticks between successive domain releases (≥1).
- `N_DOMAINS`, 3: number of reset outputs (≥1).
- `HOLD_TICKS`, 32'hDEADBEEF: continuous Fn-hold ticks that trigger a key reset (≥1, < 2^CNT_W).
- `clock` in 1: single system clock.
- `reset` in 1: asynchronous, active-high; forces every register to its reset value.
- `KEY_Fn` in 1: Fn key, active-low (0 = pressed), asynchronous to `clock`.
- `rst_out` out N_DOMAINS: per-domain reset, active-high; bit 0 is released first.
- `busy` out 1: high whenever the state is not RUN.
- `key_event` out 1: one-clock pulse when a long-press reset fires.

## Operation
- **Prescaler:** free-running `PRESCALE_W`-bit counter; `tick` = (counter == all-ones). The prescaler is never cleared except by `reset`.
- **Key synchroniser:** 2-flop synchroniser, reset value 1 (released); `key_held` = !synchronised value.
- **Counter:** one shared `CNT_W` counter `cnt`, cleared on every state change. It increments only on `tick` and saturates at all-ones.
- **States:** POR, RELEASE, RUN, KEY_RST. The reset state is POR.
  - **POR:** `rst_out` all 1. On the tick where `cnt`+1 == `POR_TICKS`, go to RELEASE with `stage` = 0.
  - **RELEASE:** `rst_out[i]` = (`stage` ≤ i). Every `STAGE_TICKS` ticks, `stage`++. When `stage` would reach `N_DOMAINS`, go to RUN. The key is ignored in this state.
  - **RUN:** `rst_out` all 0.
    - While `key_held`, `cnt` increments on ticks. When `key_held` is 0, `cnt` is cleared that cycle.
    - On the tick where `cnt`+1 == `HOLD_TICKS` with `key_held`, go to KEY_RST and pulse `key_event`.
  - **KEY_RST:** `rst_out` all 1. Stay while `key_held`. On the first cycle with `key_held` == 0, go to POR. The full POR hold always follows, which guarantees a minimum reset width.
- **Registered outputs:** `rst_out`, `busy` and `key_event` are registers updated on the same edge as the state/stage change; there is no combinational path from inputs.
- **Reset values:** `rst_out` = all 1, `busy` = 1, `key_event` = 0, state = POR, `cnt` = 0, `stage` = 0, prescaler = 0.
- **Asynchronous reset mid-sequence:** `reset` asserted in any state (including mid-RELEASE) returns immediately to POR with all outputs at their reset values.
- **Release order:** domains release strictly in order 0..N-1 and reassert simultaneously. No domain is ever released out of order.

## Timing
- Key-to-state latency is 2 clocks (synchroniser), plus up to 2^PRESCALE_W clocks of tick alignment.
- Power-on to the first `rst_out[0]` release: (`POR_TICKS` + `STAGE_TICKS`) ticks, counted from the first tick after `reset` deasserts.
- Each subsequent domain releases `STAGE_TICKS` ticks after the previous one.
- Entry to RUN happens on the same edge that releases bit N-1.
- `key_event` is high for exactly one clock, coincident with the edge where `rst_out` goes all-1.
- A key press shorter than `HOLD_TICKS` ticks has no effect. Each release restarts the count.
- A key held through power-up has no effect until RUN is reached; counting starts from 0 on entry to RUN.

## Structure
- **Shared package `reset_seq_pkg`:** state enum (POR, RELEASE, RUN, KEY_RST) and the default parameter constants.
- **Sub-module `sync_2ff`:** the generic 2-flop synchroniser, with a reset-value parameter. It is reused by other key inputs.
- The prescaler and FSM stay inline.

## Test plan
All scenarios use `PRESCALE_W`=2, `POR_TICKS`=2, `STAGE_TICKS`=1, `N_DOMAINS`=3, `HOLD_TICKS`=5, `KEY_Fn`=1 unless stated. Edge counts are from `reset` deassert.
1. **Power-up sequence:** expect `rst_out`=111 through edge 11; edge 12 → 110; edge 16 → 100; edge 20 → 000 with `busy`=0.
2. **Short press:** in RUN, hold `KEY_Fn`=0 for 4 ticks, then release → `rst_out` stays 000, `key_event` never pulses; a second 4-tick press also has no effect.
3. **Long press:** in RUN, hold `KEY_Fn`=0 → on the 5th tick, one-clock `key_event`, `rst_out`=111, `busy`=1. Hold 10 more ticks → still 111. Release → POR, then the scenario-1 sequence repeats.
4. **Asynchronous reset:** pulse `reset` mid-RELEASE when `rst_out`=100 → `rst_out`=111 immediately (before the next edge); the sequence restarts as in scenario 1.
5. **Key held through power-up:** `KEY_Fn`=0 from time 0 → sequence as in scenario 1, then RUN for exactly 5 ticks before KEY_RST.
6. **Glitch filtering:** `KEY_Fn` low for 1 clock between ticks → no state change, `cnt` stays 0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and the
// default parameter values used when the top is instantiated without overrides.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_POR,
    ST_RELEASE,
    ST_RUN,
    ST_KEY_RST
  } state_t;

  localparam int unsigned DEF_PRESCALE_W  = 16;
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_POR_TICKS   = 2;
  localparam int unsigned DEF_STAGE_TICKS = 1;
  localparam int unsigned DEF_N_DOMAINS   = 3;
  localparam logic [31:0] DEF_HOLD_TICKS  = 32'hDEADBEEF;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
// Ports:
//   i_clk  - destination clock
//   i_rst  - asynchronous active-high reset, loads RESET_VAL into both flops
//   i_d    - asynchronous input
//   o_q    - synchronised output (2-clock latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// N-domain reset sequencer: power-on hold, ordered per-domain release, and a
// long-press Fn-key reset that re-runs the whole sequence.
// Ports:
//   clock     - system clock
//   reset     - asynchronous active-high board reset
//   KEY_Fn    - Fn key, active-low, asynchronous to clock
//   rst_out   - per-domain active-high resets, bit 0 released first
//   busy      - high whenever the sequencer is not in RUN
//   key_event - one-clock pulse when a long-press reset fires
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned       PRESCALE_W  = DEF_PRESCALE_W,
  parameter int unsigned       CNT_W       = DEF_CNT_W,
  parameter int unsigned       POR_TICKS   = DEF_POR_TICKS,
  parameter int unsigned       STAGE_TICKS = DEF_STAGE_TICKS,
  parameter int unsigned       N_DOMAINS   = DEF_N_DOMAINS,
  parameter logic [CNT_W-1:0]  HOLD_TICKS  = CNT_W'(DEF_HOLD_TICKS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 KEY_Fn,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 busy,
  output logic                 key_event
);

  localparam int unsigned STAGE_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PRESCALE_W-1:0] r_presc;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [CNT_W-1:0]      w_cnt_adv;
  logic [STAGE_W-1:0]    r_stage;
  logic [STAGE_W-1:0]    w_stage_nxt;
  logic [N_DOMAINS-1:0]  r_rst_out;
  logic [N_DOMAINS-1:0]  w_rst_nxt;
  logic                  r_busy;
  logic                  r_key_event;
  logic                  w_key_event_nxt;
  logic                  w_key_sync;
  logic                  w_key_held;
  logic                  w_tick;

  sync_2ff #(.RESET_VAL(1'b1)) u_key_sync (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (KEY_Fn),
    .o_q   (w_key_sync)
  );

  assign w_key_held = ~w_key_sync;
  assign w_tick     = &r_presc;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_cnt_adv  = (&r_cnt) ? r_cnt : w_cnt_inc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc     <= '0;
      r_state     <= ST_POR;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_rst_out   <= '1;
      r_busy      <= 1'b1;
      r_key_event <= 1'b0;
    end else begin
      r_presc     <= r_presc + 1'b1;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_stage     <= w_stage_nxt;
      r_rst_out   <= w_rst_nxt;
      r_busy      <= (w_state_nxt != ST_RUN);
      r_key_event <= w_key_event_nxt;
    end
  end

  // The stage counter reuses the shared tick counter, so it is cleared on each
  // stage step as well as on every state change.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_stage_nxt     = r_stage;
    w_key_event_nxt = 1'b0;
    unique case (r_state)
      ST_POR: begin
        if (w_tick) begin
          if (w_cnt_inc == CNT_W'(POR_TICKS)) begin
            w_state_nxt = ST_RELEASE;
            w_stage_nxt = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_adv;
          end
        end
      end
      ST_RELEASE: begin
        if (w_tick) begin
          if (w_cnt_inc == CNT_W'(STAGE_TICKS)) begin
            w_cnt_nxt = '0;
            if (r_stage == STAGE_W'(N_DOMAINS - 1)) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_stage_nxt = r_stage + 1'b1;
            end
          end else begin
            w_cnt_nxt = w_cnt_adv;
          end
        end
      end
      ST_RUN: begin
        if (!w_key_held) begin
          w_cnt_nxt = '0;
        end else if (w_tick) begin
          if (w_cnt_inc == HOLD_TICKS) begin
            w_state_nxt     = ST_KEY_RST;
            w_cnt_nxt       = '0;
            w_key_event_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_adv;
          end
        end
      end
      ST_KEY_RST: begin
        if (!w_key_held) begin
          w_state_nxt = ST_POR;
          w_cnt_nxt   = '0;
        end else if (w_tick) begin
          w_cnt_nxt = w_cnt_adv;
        end
      end
      default: begin
        w_state_nxt = ST_POR;
        w_cnt_nxt   = '0;
        w_stage_nxt = '0;
      end
    endcase
  end

  // Output image is computed from the next state so the registered outputs
  // change on the same edge as the state/stage.
  always_comb begin
    w_rst_nxt = '1;
    unique case (w_state_nxt)
      ST_RELEASE: begin
        for (int unsigned i = 0; i < N_DOMAINS; i++) begin
          w_rst_nxt[i] = (32'(w_stage_nxt) <= i);
        end
      end
      ST_RUN:  w_rst_nxt = '0;
      default: w_rst_nxt = '1;
    endcase
  end

  assign rst_out   = r_rst_out;
  assign busy      = r_busy;
  assign key_event = r_key_event;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int unsigned ND = 3;

  typedef struct {
    int          e;
    logic [2:0]  rst;
    logic        busy;
    logic        kev;
    string       tag;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          key_n = 1'b1;
  logic [ND-1:0] rst_out;
  logic          busy;
  logic          key_event;

  int   edge_n    = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;
  exp_t sb[$];

  reset_sequencer #(
    .PRESCALE_W  (2),
    .CNT_W       (32),
    .POR_TICKS   (2),
    .STAGE_TICKS (1),
    .N_DOMAINS   (ND),
    .HOLD_TICKS  (32'd5)
  ) dut (
    .clock     (clk),
    .reset     (rst),
    .KEY_Fn    (key_n),
    .rst_out   (rst_out),
    .busy      (busy),
    .key_event (key_event)
  );

  always #5 clk = ~clk;

  // Edge index since the last reset deassert; edge 1 is the first posedge.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Power-up image relative to reset deassert.
  function automatic logic [2:0] seq_rst(input int e);
    if (e < 12)      return 3'b111;
    else if (e < 16) return 3'b110;
    else if (e < 20) return 3'b100;
    else             return 3'b000;
  endfunction

  task automatic push_one(input string tag, input int e, input logic [2:0] r,
                          input logic b, input logic k);
    exp_t x;
    x.e = e; x.rst = r; x.busy = b; x.kev = k;
    x.tag = $sformatf("%s@%0d", tag, e);
    sb.push_back(x);
  endtask

  task automatic push_seq(input string tag, input int e0, input int e1, input int off);
    for (int e = e0; e <= e1; e++)
      push_one(tag, e, seq_rst(e - off), (e - off) < 20, 1'b0);
  endtask

  task automatic push_const(input string tag, input int e0, input int e1,
                            input logic [2:0] r, input logic b, input logic k);
    for (int e = e0; e <= e1; e++) push_one(tag, e, r, b, k);
  endtask

  // Returns 1ns after the negedge following edge e, after the monitor ran.
  task automatic wait_edge(input int e);
    int guard;
    guard = 0;
    while (edge_n != e && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_n != e) check_val("wait_edge_timeout", edge_n, e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    while (sb.size() > 0 && sb[0].e == edge_n) begin
      x = sb.pop_front();
      check_val({x.tag, "_rst"},  rst_out,   x.rst);
      check_val({x.tag, "_busy"}, busy,      x.busy);
      check_val({x.tag, "_kev"},  key_event, x.kev);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("reset_rst",  rst_out,   3'b111);
    check_val("reset_busy", busy,      1'b1);
    check_val("reset_kev",  key_event, 1'b0);
    #1 rst = 1'b0;

    // Power-up sequence
    push_seq("s1", 1, 24, 0);
    wait_edge(24);

    // Two short presses of 4 ticks each
    push_const("s2", 25, 72, 3'b000, 1'b0, 1'b0);
    key_n = 1'b0;
    wait_edge(40); key_n = 1'b1;
    wait_edge(48); key_n = 1'b0;
    wait_edge(64); key_n = 1'b1;
    wait_edge(72);

    // Long press, extended hold, release re-runs power-up
    push_const("s3_run",  73, 91,  3'b000, 1'b0, 1'b0);
    push_const("s3_fire", 92, 92,  3'b111, 1'b1, 1'b1);
    push_const("s3_hold", 93, 132, 3'b111, 1'b1, 1'b0);
    key_n = 1'b0;
    wait_edge(132);
    key_n = 1'b1;
    push_seq("s3_repor", 133, 156, 132);
    wait_edge(156);

    // Key held through power-up
    check_val("s5_sb_drained", sb.size(), 0);
    rst = 1'b1; key_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    push_seq("s5", 1, 19, 0);
    push_const("s5_run",  20, 39, 3'b000, 1'b0, 1'b0);
    push_const("s5_fire", 40, 40, 3'b111, 1'b1, 1'b1);
    push_const("s5_krst", 41, 44, 3'b111, 1'b1, 1'b0);
    wait_edge(44);

    // Asynchronous reset mid-release
    check_val("s4_sb_drained", sb.size(), 0);
    rst = 1'b1; key_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    push_seq("s4_pre", 1, 17, 0);
    wait_edge(17);
    check_val("s4_pre_drained", sb.size(), 0);
    rst = 1'b1;
    #1;
    check_val("s4_async_rst",  rst_out,   3'b111);
    check_val("s4_async_busy", busy,      1'b1);
    check_val("s4_async_kev",  key_event, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    push_seq("s4_restart", 1, 24, 0);
    wait_edge(24);

    // One-clock glitch between ticks, then an exact 5-tick press
    push_const("s6_glitch", 25, 47, 3'b000, 1'b0, 1'b0);
    push_const("s6_fire",   48, 48, 3'b111, 1'b1, 1'b1);
    push_const("s6_krst",   49, 50, 3'b111, 1'b1, 1'b0);
    key_n = 1'b0;
    @(negedge clk);
    #1 key_n = 1'b1;
    wait_edge(28); key_n = 1'b0;
    wait_edge(50); key_n = 1'b1;
    wait_edge(52);
    check_val("final_sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
